// File: rtl/def.sv
// Shared types and encodings for the multi-cycle MIPS control FSM.
package def;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_REXEC  = 4'd7,
        S_RWB    = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_TRAP   = 4'd13
    } ctrlState;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_AND = 3'd0,
        ALU_OR  = 3'd1,
        ALU_ADD = 3'd2,
        ALU_SUB = 3'd6,
        ALU_SLT = 3'd7
    } aluCtlType;

endpackage

// File: rtl/alu_ctl_dec.sv
// R-type funct decoder: ALU operation plus a flag for unsupported funct codes.
module alu_ctl_dec
    import def::*;
(
    input  logic [5:0] funct,
    output aluCtlType  alu_ctl,
    output logic       valid
);

    always_comb begin
        alu_ctl = ALU_AND;
        valid   = 1'b1;
        case (funct)
            FN_ADD:  alu_ctl = ALU_ADD;
            FN_SUB:  alu_ctl = ALU_SUB;
            FN_AND:  alu_ctl = ALU_AND;
            FN_OR:   alu_ctl = ALU_OR;
            FN_SLT:  alu_ctl = ALU_SLT;
            default: valid   = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// handshakes with a variable-latency memory, traps bad opcodes, counts retirements.
module multicycle_ctrl
    import def::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             memReady,
    output logic             memRead,
    output logic             memWrite,
    output logic             iorD,
    output logic             irWrite,
    output logic             pcEn,
    output logic [1:0]       pcSource,
    output logic             aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [2:0]       aluCtl,
    output logic             regDst,
    output logic             memToReg,
    output logic             regWrite,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    ctrlState  cur_state;
    ctrlState  nxt_state;
    aluCtlType dec_ctl;
    logic      dec_valid;
    logic      retire;

    alu_ctl_dec u_alu_ctl_dec (
        .funct   (funct),
        .alu_ctl (dec_ctl),
        .valid   (dec_valid)
    );

    assign state = cur_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= S_IDLE;
            retired   <= '0;
            illegal   <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            if (retire) begin
                retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            // Sticky: TRAP is absorbing, so only reset clears it.
            if (nxt_state == S_TRAP) begin
                illegal <= 1'b1;
            end
        end
    end

    // Mealy terms (irWrite/pcEn in FETCH, pcEn in BRANCH, memory-state exits)
    // depend on memReady/zero in the current cycle.
    always_comb begin
        nxt_state = cur_state;
        retire    = 1'b0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        iorD      = 1'b0;
        irWrite   = 1'b0;
        pcEn      = 1'b0;
        pcSource  = 2'd0;
        aluSrcA   = 1'b0;
        aluSrcB   = 2'd0;
        aluCtl    = 3'd0;
        regDst    = 1'b0;
        memToReg  = 1'b0;
        regWrite  = 1'b0;
        case (cur_state)
            S_IDLE: nxt_state = S_FETCH;
            S_FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'd1;
                aluCtl  = ALU_ADD;
                irWrite = memReady;
                pcEn    = memReady;
                if (memReady) nxt_state = S_DECODE;
            end
            S_DECODE: begin
                aluSrcB = 2'd3;
                aluCtl  = ALU_ADD;
                case (opcode)
                    OP_RTYPE:     nxt_state = S_REXEC;
                    OP_LW, OP_SW: nxt_state = S_MEMADR;
                    OP_ADDI:      nxt_state = S_IEXEC;
                    OP_BEQ:       nxt_state = S_BRANCH;
                    OP_J:         nxt_state = S_JUMP;
                    default:      nxt_state = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                aluSrcA   = 1'b1;
                aluSrcB   = 2'd2;
                aluCtl    = ALU_ADD;
                nxt_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
                if (memReady) nxt_state = S_MEMWB;
            end
            S_MEMWB: begin
                regWrite  = 1'b1;
                memToReg  = 1'b1;
                retire    = 1'b1;
                nxt_state = S_FETCH;
            end
            S_MEMWR: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
                if (memReady) begin
                    retire    = 1'b1;
                    nxt_state = S_FETCH;
                end
            end
            S_REXEC: begin
                aluSrcA   = 1'b1;
                aluCtl    = dec_ctl;
                nxt_state = dec_valid ? S_RWB : S_TRAP;
            end
            S_RWB: begin
                regWrite  = 1'b1;
                regDst    = 1'b1;
                retire    = 1'b1;
                nxt_state = S_FETCH;
            end
            S_IEXEC: begin
                aluSrcA   = 1'b1;
                aluSrcB   = 2'd2;
                aluCtl    = ALU_ADD;
                nxt_state = S_IWB;
            end
            S_IWB: begin
                regWrite  = 1'b1;
                retire    = 1'b1;
                nxt_state = S_FETCH;
            end
            S_BRANCH: begin
                aluSrcA   = 1'b1;
                aluCtl    = ALU_SUB;
                pcSource  = 2'd1;
                pcEn      = zero;
                retire    = 1'b1;
                nxt_state = S_FETCH;
            end
            S_JUMP: begin
                pcSource  = 2'd2;
                pcEn      = 1'b1;
                retire    = 1'b1;
                nxt_state = S_FETCH;
            end
            S_TRAP:  nxt_state = S_TRAP;
            default: nxt_state = S_IDLE;
        endcase
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control FSM for the multi-cycle MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives the select and strobe signals consumed by the decode stage (`regDst`, `memToReg`, `regWrite`), the ALU, the PC and the unified instruction/data memory. Also handshakes with a variable-latency memory, traps illegal opcodes and counts retired instructions.

## Interface
- Parameters: `CNT_W`, default 32, width of the retired-instruction counter.
- Clock and reset are fixed: one clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  `instr[31:26]`; valid only while the IR is stable (DECODE onward).
- `funct`  in  6  `instr[5:0]`.
- `zero`  in  1  ALU zero flag, used in BRANCH.
- `memReady`  in  1  memory completes the current access this cycle.
- `memRead`, `memWrite`  out  1  memory request strobes.
- `iorD`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `irWrite`  out  1  load the IR.
- `pcEn`  out  1  PC write enable.
- `pcSource`  out  2  PC source: 0 = ALU, 1 = ALUOut, 2 = jump target.
- `aluSrcA`  out  1  ALU A select: 0 = PC, 1 = rs.
- `aluSrcB`  out  2  ALU B select: 0 = rt, 1 = 4, 2 = signExtend, 3 = signExtend<<2.
- `aluCtl`  out  3  0 = AND, 1 = OR, 2 = ADD, 6 = SUB, 7 = SLT.
- `regDst`, `memToReg`, `regWrite`  out  1  decode-stage controls.
- `illegal`  out  1  sticky trap flag.
- `retired`  out  `CNT_W`  count of completed instructions.
- `state`  out  4  current state, for debug.

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, RWB, IEXEC, IWB, BRANCH, JUMP, TRAP.
- IDLE → FETCH unconditionally.
- FETCH
  - Drives `memRead=1`, `iorD=0`, `aluSrcA=0`, `aluSrcB=1`, `aluCtl=ADD`, `pcSource=0`.
  - Holds while `memReady=0`.
  - On `memReady=1`: `irWrite=1` and `pcEn=1` in the same cycle (Mealy), then go to DECODE.
- DECODE
  - Drives `aluSrcA=0`, `aluSrcB=3`, `aluCtl=ADD` to compute the branch target.
  - Dispatch on `opcode`:
    - 0x00 → REXEC
    - 0x23 / 0x2B → MEMADR
    - 0x08 → IEXEC
    - 0x04 → BRANCH
    - 0x02 → JUMP
    - any other value → TRAP
- MEMADR: `aluSrcA=1`, `aluSrcB=2`, ADD. Go to MEMRD if `opcode`=0x23, else MEMWR.
- MEMRD: `memRead=1`, `iorD=1`. Hold until `memReady`, then go to MEMWB.
- MEMWB: `regWrite=1`, `memToReg=1`, `regDst=0`. Go to FETCH.
- MEMWR: `memWrite=1`, `iorD=1`. Hold until `memReady`, then go to FETCH.
- REXEC: `aluSrcA=1`, `aluSrcB=0`. `aluCtl` from `funct`:
  - 0x20 → ADD
  - 0x22 → SUB
  - 0x24 → AND
  - 0x25 → OR
  - 0x2A → SLT
  - any other `funct` → next state TRAP instead of RWB.
- RWB: `regWrite=1`, `regDst=1`, `memToReg=0`. Go to FETCH.
- IEXEC: `aluSrcA=1`, `aluSrcB=2`, ADD. Go to IWB.
- IWB: `regWrite=1`, `regDst=0`, `memToReg=0`. Go to FETCH.
- BRANCH: `aluSrcA=1`, `aluSrcB=0`, SUB, `pcSource=1`, `pcEn=zero` (Mealy). Go to FETCH.
- JUMP: `pcSource=2`, `pcEn=1`. Go to FETCH.
- TRAP: absorbing state. All strobes are 0; `illegal` is set on entry and stays set until reset.
- Default for every output not listed for a state: 0.
- `retired` increments (wrapping) on the final cycle of each instruction: MEMWB, MEMWR with `memReady`, RWB, IWB, BRANCH, JUMP.

## Timing
- Reset, while `rst` is low: state IDLE, all outputs 0, `retired`=0, `illegal`=0.
- Fetch begins in the second cycle after `rst` deasserts.
- Latency with zero-wait memory (`memReady` held 1):
  - lw: 5 cycles
  - R-type, addi, sw: 4 cycles
  - beq, j: 3 cycles
- Each wait cycle adds one cycle in FETCH, MEMRD or MEMWR.
- Memory handshake:
  - The request strobe stays constant until it is accepted.
  - `memReady` is ignored in all states except FETCH, MEMRD and MEMWR.
  - A `memReady` pulse arriving in the same cycle the strobe first rises completes the access.
- Reset asserted mid-instruction: state goes to IDLE immediately. No `regWrite` or `memWrite` may be seen after `rst` falls.
- `retired` wraps from all-ones to 0.

## Structure
- Package `def` holds:
  - `ctrlState` enum (4-bit)
  - opcode constants (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_ADDI`, `OP_BEQ`, `OP_J`)
  - funct constants
  - `aluCtlType` enum
- Sub-module `alu_ctl_dec`: combinational `funct` → {`aluCtl`, `valid`}, instantiated for REXEC.
- State register and counter live in one `always_ff` block; output decode lives in one `always_comb` block.

## Test plan
- Reset, then `memReady`=1, lw (0x23): states IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. `regWrite`=`memToReg`=1 only in MEMWB. `retired`=1.
- add (opcode 0, `funct` 0x20), then slt (0x2A): `aluCtl`=2 in REXEC, then `aluCtl`=7. `regDst`=1 in RWB. `retired`=2.
- beq with `zero`=1, then with `zero`=0: `pcEn`=1 and `pcSource`=1 in BRANCH for the first, `pcEn`=0 for the second.
- sw with `memReady` low for 3 cycles in MEMWR: `memWrite` held for 4 cycles, `iorD`=1, `retired` increments once, on the accept cycle.
- Opcode 0x3F, then R-type with `funct` 0x00: TRAP, `illegal`=1, all strobes 0 for 20 cycles, `retired` unchanged.
- Reset pulsed during MEMRD: all outputs 0 asynchronously. After release, IDLE then FETCH. `retired`=0.
